// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive deserialiser:
//   - DEFAULT_CLKS_PER_BIT : default bit period in clk cycles (50 MHz / 115200)
//   - DATA_BITS            : payload bits per frame (8N1)
//   - IDLE..BREAK          : 3-bit receiver FSM state encodings
//   - rx_state_t           : enum built from those encodings
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS            = 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = IDLE,
    S_START = START,
    S_DATA  = DATA,
    S_STOP  = STOP,
    S_BREAK = BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_deser_if.sv
// -----------------------------------------------------------------------------
// uart_rx_deser_if
// Byte-side interface of the UART receiver towards the RX register block.
//   rx_data        : last accepted byte
//   rx_data_valid  : rx_data holds an unconsumed byte
//   rx_data_ready  : consumer takes rx_data in any cycle where valid is high
//   frame_err      : one-cycle pulse, stop bit sampled low
//   overrun        : one-cycle pulse, a new byte replaced an unconsumed one
// master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_deser_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_data_valid;
  logic                 rx_data_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_data_valid,
    output frame_err,
    output overrun,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_data_valid,
    input  frame_err,
    input  overrun,
    output rx_data_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input.
//   clk : destination clock
//   rst : synchronous active-high reset, both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronised output, 2 cycles behind d
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
// 8N1 UART receiver, LSB first. Synchronises rx_pin, times each bit with a
// cycle counter, checks start/stop bits and hands bytes out on valid/ready.
//   clk    : system clock, all logic on rising edge
//   rst    : synchronous active-high reset
//   rx_pin : asynchronous serial line, idle high
//   rx     : byte-side interface (rx_data, rx_data_valid, rx_data_ready,
//            frame_err, overrun)
// -----------------------------------------------------------------------------
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_pin,
  uart_rx_deser_if.master rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // Synchronised line; every FSM decision looks only at this.
  logic rxs;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_pin),
    .q   (rxs)
  );

  rx_state_t             state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [DATA_BITS-1:0]  shift_reg, shift_next;

  logic                  sample_data;
  logic                  byte_done;
  logic                  stop_err;

  logic [DATA_BITS-1:0]  data_reg;
  logic                  valid_reg;
  logic                  frame_err_reg;
  logic                  overrun_reg;

  // ---------------------------------------------------------------------------
  // FSM state and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  // Counter is cleared on every state change, so it can never wrap.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + 1'b1;
    idx_next    = idx_reg;
    sample_data = 1'b0;
    byte_done   = 1'b0;
    stop_err    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (!rxs) begin
          state_next = S_START;
        end
      end

      // Re-check the start bit at its middle; a short low pulse is a glitch.
      S_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rxs ? S_IDLE : S_DATA;
        end
      end

      // From the mid-start point, one full bit period lands mid-data-bit.
      S_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next    = '0;
          sample_data = 1'b1;
          if (idx_reg == IDX_LAST) begin
            state_next = S_STOP;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end

      // Sampling mid-stop leaves half a bit to catch a back-to-back start.
      S_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rxs) begin
            byte_done  = 1'b1;
            state_next = S_IDLE;
          end else begin
            stop_err   = 1'b1;
            state_next = S_BREAK;
          end
        end
      end

      // Held-low line: wait for it to return high before hunting for a start.
      S_BREAK: begin
        cnt_next = '0;
        if (rxs) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Per-bit write enable into the shift register, LSB first.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      assign shift_next[gi] = (sample_data && (idx_reg == IDX_W'(gi))) ? rxs
                                                                       : shift_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output byte register and handshake
  // ---------------------------------------------------------------------------
  // A completing byte always wins: it is loaded even if the old one is still
  // unconsumed (overrun flagged) or being consumed this very cycle (no flag).
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= stop_err;
      overrun_reg   <= 1'b0;
      if (byte_done) begin
        data_reg    <= shift_reg;
        valid_reg   <= 1'b1;
        overrun_reg <= valid_reg & ~rx.rx_data_ready;
      end else if (valid_reg && rx.rx_data_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx.rx_data       = data_reg;
  assign rx.rx_data_valid = valid_reg;
  assign rx.frame_err     = frame_err_reg;
  assign rx.overrun       = overrun_reg;

endmodule

// File: tb/tb_uart_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deser
// Directed bench for uart_rx_deser with CLKS_PER_BIT=16. A table of frames is
// replayed with hand-computed results, followed by hand-written sequences for
// glitch rejection, overrun, ready-held-high streaming and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_uart_rx_deser;

  localparam int CPB = 16;
  // Start edge to valid: 2 sync + CPB/2 + 9*CPB.
  localparam int NOMINAL_LAT = 2 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_pin = 1'b1;

  uart_rx_deser_if rx_if ();

  uart_rx_deser #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_pin (rx_pin),
    .rx     (rx_if.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Monitor: logs valid rises, valid run lengths and flag pulses
  // ---------------------------------------------------------------------------
  logic [7:0] rise_data[$];
  int         rise_cyc[$];
  int         vlen[$];
  int         run = 0;
  int         fe_pulses = 0, fe_high = 0, ov_pulses = 0, ov_high = 0;
  logic       v_d = 1'b0, fe_d = 1'b0, ov_d = 1'b0;

  always @(negedge clk) begin
    if (rx_if.rx_data_valid && !v_d) begin
      rise_data.push_back(rx_if.rx_data);
      rise_cyc.push_back(cyc);
    end
    if (rx_if.rx_data_valid) begin
      run++;
    end else if (v_d) begin
      vlen.push_back(run);
      run = 0;
    end
    if (rx_if.frame_err) begin
      fe_high++;
      if (!fe_d) fe_pulses++;
    end
    if (rx_if.overrun) begin
      ov_high++;
      if (!ov_d) ov_pulses++;
    end
    v_d  = rx_if.rx_data_valid;
    fe_d = rx_if.frame_err;
    ov_d = rx_if.overrun;
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic check_lat(input string name, input int lat);
    total++;
    if (lat < NOMINAL_LAT - 2 || lat > NOMINAL_LAT + 2) begin
      bad++;
      $display("FAIL %s: latency %0d, expected %0d +/-2", name, lat, NOMINAL_LAT);
    end else begin
      $display("ok   %s: latency %0d", name, lat);
    end
  endtask

  task automatic fail_missing(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no record, expected one", name);
  endtask

  // Drives one frame aligned to falling edges; leaves the line at stop_bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_pin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_pin = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  // One-cycle ready pulse; valid must be low in the following cycle.
  task automatic consume(input string name);
    rx_if.rx_data_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_data_ready = 1'b0;
    check(name, rx_if.rx_data_valid, 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int r0, f0, fh0, c0, o0, oh0, l0;
    logic [7:0] exp_stream[3];
    logic [7:0] b99;

    vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_valid: 1'b1, exp_data: 8'hA5, exp_fe: 0};
    vecs[1] = '{data: 8'h55, stop_bit: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_fe: 1};
    vecs[2] = '{data: 8'h0F, stop_bit: 1'b1, exp_valid: 1'b1, exp_data: 8'h0F, exp_fe: 0};
    vecs[3] = '{data: 8'hC3, stop_bit: 1'b1, exp_valid: 1'b1, exp_data: 8'hC3, exp_fe: 0};
    vecs[4] = '{data: 8'h80, stop_bit: 1'b1, exp_valid: 1'b1, exp_data: 8'h80, exp_fe: 0};

    rx_if.rx_data_ready = 1'b0;
    rst    = 1'b1;
    rx_pin = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  rx_if.rx_data, 8'h00);
    check("rst_valid", rx_if.rx_data_valid, 1'b0);
    check("rst_fe",    rx_if.frame_err, 1'b0);
    check("rst_ov",    rx_if.overrun, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // ---- table-driven frames ------------------------------------------------
    for (int v = 0; v < 5; v++) begin
      r0  = rise_data.size();
      f0  = fe_pulses;
      fh0 = fe_high;
      c0  = cyc;
      send_frame(vecs[v].data, vecs[v].stop_bit);
      if (!vecs[v].stop_bit) begin
        repeat (40) @(negedge clk);
        rx_pin = 1'b1;
      end
      repeat (CPB) @(negedge clk);
      check($sformatf("v%0d_valid", v), rx_if.rx_data_valid, vecs[v].exp_valid);
      check($sformatf("v%0d_rises", v), rise_data.size() - r0, vecs[v].exp_valid);
      check($sformatf("v%0d_fe_pulses", v), fe_pulses - f0, vecs[v].exp_fe);
      check($sformatf("v%0d_fe_width", v), fe_high - fh0, vecs[v].exp_fe);
      if (vecs[v].exp_valid) begin
        check($sformatf("v%0d_data", v), rx_if.rx_data, vecs[v].exp_data);
        // cyc at the sampling negedge counts the posedge after the start edge.
        if (rise_cyc.size() > r0) check_lat($sformatf("v%0d_lat", v), rise_cyc[r0] - c0 - 1);
        else fail_missing($sformatf("v%0d_lat", v));
        repeat (10) @(negedge clk);
        check($sformatf("v%0d_hold_data", v), rx_if.rx_data, vecs[v].exp_data);
        check($sformatf("v%0d_hold_valid", v), rx_if.rx_data_valid, 1'b1);
        consume($sformatf("v%0d_consume", v));
      end
      repeat (5) @(negedge clk);
    end

    // ---- short low glitch is ignored, following frame is fine ---------------
    r0 = rise_data.size();
    f0 = fe_pulses;
    rx_pin = 1'b0;
    repeat (4) @(negedge clk);
    rx_pin = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_rises", rise_data.size() - r0, 0);
    check("glitch_fe",    fe_pulses - f0, 0);
    check("glitch_valid", rx_if.rx_data_valid, 1'b0);
    send_frame(8'h3C, 1'b1);
    repeat (CPB) @(negedge clk);
    check("glitch_next_data",  rx_if.rx_data, 8'h3C);
    check("glitch_next_valid", rx_if.rx_data_valid, 1'b1);
    consume("glitch_next_consume");
    repeat (5) @(negedge clk);

    // ---- overrun: two frames, never consumed in between ---------------------
    o0  = ov_pulses;
    oh0 = ov_high;
    send_frame(8'h11, 1'b1);
    check("ovr_first_data",  rx_if.rx_data, 8'h11);
    check("ovr_first_valid", rx_if.rx_data_valid, 1'b1);
    check("ovr_first_noov",  ov_pulses - o0, 0);
    send_frame(8'h22, 1'b1);
    repeat (CPB) @(negedge clk);
    check("ovr_second_data",  rx_if.rx_data, 8'h22);
    check("ovr_second_valid", rx_if.rx_data_valid, 1'b1);
    check("ovr_pulses",       ov_pulses - o0, 1);
    check("ovr_width",        ov_high - oh0, 1);
    consume("ovr_consume");
    repeat (5) @(negedge clk);

    // ---- ready held high, back-to-back stream -------------------------------
    exp_stream[0] = 8'h00;
    exp_stream[1] = 8'hFF;
    exp_stream[2] = 8'h81;
    r0 = rise_data.size();
    l0 = vlen.size();
    o0 = ov_pulses;
    rx_if.rx_data_ready = 1'b1;
    for (int k = 0; k < 3; k++) send_frame(exp_stream[k], 1'b1);
    repeat (CPB) @(negedge clk);
    rx_if.rx_data_ready = 1'b0;
    check("stream_rises", rise_data.size() - r0, 3);
    for (int k = 0; k < 3; k++) begin
      if (rise_data.size() > r0 + k) check($sformatf("stream%0d_data", k), rise_data[r0 + k], exp_stream[k]);
      else fail_missing($sformatf("stream%0d_data", k));
      if (vlen.size() > l0 + k) check($sformatf("stream%0d_width", k), vlen[l0 + k], 1);
      else fail_missing($sformatf("stream%0d_width", k));
    end
    check("stream_noov",  ov_pulses - o0, 0);
    check("stream_valid", rx_if.rx_data_valid, 1'b0);
    repeat (5) @(negedge clk);

    // ---- reset mid-DATA with a byte pending ---------------------------------
    send_frame(8'h42, 1'b1);
    repeat (CPB) @(negedge clk);
    check("pend_valid", rx_if.rx_data_valid, 1'b1);
    b99 = 8'h99;
    rx_pin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rx_pin = b99[i];
      repeat (CPB) @(negedge clk);
    end
    rx_pin = b99[2];
    repeat (CPB / 2) @(negedge clk);
    rst    = 1'b1;
    rx_pin = 1'b1;
    @(negedge clk);
    check("mrst_data",  rx_if.rx_data, 8'h00);
    check("mrst_valid", rx_if.rx_data_valid, 1'b0);
    check("mrst_fe",    rx_if.frame_err, 1'b0);
    check("mrst_ov",    rx_if.overrun, 1'b0);
    rst = 1'b0;
    r0  = rise_data.size();
    repeat (3 * CPB) @(negedge clk);
    check("mrst_idle_rises", rise_data.size() - r0, 0);
    send_frame(8'h7E, 1'b1);
    repeat (CPB) @(negedge clk);
    check("mrst_next_data",  rx_if.rx_data, 8'h7E);
    check("mrst_next_valid", rx_if.rx_data_valid, 1'b1);
    consume("mrst_next_consume");
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
Serial-to-parallel UART receive core, 8N1, LSB first. It sits between the external rx pin and the UART RX GPIO register block. It synchronises the pin, times bits with a clock-cycle counter, validates start and stop bits, and presents each received byte on a valid/ready handshake. The GPIO block drives ready from bit 0 of its RXCTRL register and reads valid as RXSTATUS.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); must be >= 8.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
rx_pin  input  1  asynchronous serial line, idle high
rx_data  output  8  last accepted byte
rx_data_valid  output  1  rx_data holds an unconsumed byte
rx_data_ready  input  1  consumer accepts rx_data in any cycle where valid is also high
frame_err  output  1  one-cycle pulse, stop bit sampled low
overrun  output  1  one-cycle pulse, new byte overwrote an unconsumed byte

Behaviour:
- Reset values (synchronous, active-high rst):
  - rx_data=0, rx_data_valid=0, frame_err=0, overrun=0.
  - Both sync flops=1. State=IDLE, bit counter=0, bit index=0.
- Reset mid-frame: the partial byte is discarded. A pending valid byte is also dropped.
- Synchroniser: 2 flops on rx_pin; all FSM decisions use the second flop (rxs). Pin-to-rxs latency is 2 cycles.
- IDLE:
  - On rxs==0: clear counter, go to START.
- START:
  - Count to CLKS_PER_BIT/2-1 (integer division), then sample rxs.
  - rxs==0: clear counter, bit index=0, go to DATA.
  - rxs==1: treat as a glitch and return to IDLE. No flag is raised.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rxs into shift register bit [bit index], LSB first.
  - After index 7 is sampled, go to STOP. Otherwise increment the index.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rxs.
  - rxs==1: byte complete, go to IDLE.
  - rxs==0: frame_err pulses high for 1 cycle, the byte is discarded, go to BREAK.
- BREAK:
  - Wait for rxs==1, then go to IDLE. A held-low line never produces bytes.
- Byte complete: on the cycle after the stop sample, rx_data is loaded and rx_data_valid=1.
- Handshake:
  - valid&ready in cycle N gives valid=0 in cycle N+1.
  - rx_data is held stable while valid=1, except on overwrite.
  - ready while valid=0 has no effect.
  - ready held permanently high consumes each byte 1 cycle after it appears.
- Simultaneous events:
  - Byte completes while valid=1 and ready=0: new byte overwrites (latest wins), valid stays 1, overrun pulses 1 cycle.
  - Byte completes in the same cycle as valid&ready: new byte loaded, valid stays 1, no overrun.
- Counters: bit counter width is $clog2(CLKS_PER_BIT); bit index is 3 bits. Neither wraps, because both are cleared on every state entry.
- Back-to-back frames:
  - The next start edge may arrive immediately after the stop-bit sample point. IDLE detects it on the next rxs low.
  - Sampling at mid-stop keeps detection of the following start within half a bit.
- Nominal latency from the rx_pin start edge to valid:
  - 2 sync cycles + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT, plus state-entry cycles.
  - The bench must check valid within ±2 cycles of this figure.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding localparams: IDLE, START, DATA, STOP, BREAK (3-bit).
  - DEFAULT_CLKS_PER_BIT=434.
  - DATA_BITS=8.
- One natural sub-module: sync_2ff, a reusable 2-flop synchroniser with reset value parameter (1 here).
- FSM, counters and handshake stay in uart_rx_deser.

Test Plan:
1. CLKS_PER_BIT=16, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop), ready=0 -> valid rises ~154 cycles after start edge, rx_data=0xA5, held; assert ready 1 cycle -> valid=0 next cycle.
2. Drive rx_pin low for 4 cycles, then high -> returns to IDLE; no valid, no frame_err; a following 0x3C frame is received correctly.
3. Send 0x55 with stop bit low, line held low 40 cycles, then high -> frame_err one pulse, no valid; after line high, 0x0F received normally.
4. ready=0, send 0x11 then 0x22 back-to-back -> first valid with 0x11; at second completion rx_data=0x22, valid stays 1, overrun one pulse.
5. ready tied high, send 0x00, 0xFF, 0x81 back-to-back -> each appears with valid high exactly 1 cycle, values in order, no overrun.
6. Assert rst mid-DATA of 0x99 with valid=1 pending -> next cycle all outputs 0; then send 0x7E -> received cleanly.
